// File: rtl/ks_voice_sequencer.sv
// ks_voice_sequencer
//
// Per-voice note sequencer for the plucked-string loop. A note request is
// checked against the minimum loop length and then walks through
// LOOKUP -> EXCITE -> SUSTAIN -> RELEASE -> IDLE:
//   LOOKUP  : one cycle; the registered lutDelay has reached the
//             combinational delay-to-gain LUT, and its answer is captured.
//   EXCITE  : the delay line is filled with noise for exactly delay samples.
//   SUSTAIN : the string rings with the LUT gain until noteOff or timeout.
//   RELEASE : heavy damping gain for RELEASE_TICKS samples, then IDLE.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   sampleTick    one-cycle pulse per audio sample
//   noteOn        note request strobe, noteDelay sampled with it
//   noteOff       note release strobe
//   noteDelay     requested loop length (DELAY_W)
//   lutMul        gain returned by the LUT for lutDelay (GAIN_W)
//   lutDelay      loop length presented to the LUT
//   delayLen      active loop length for the delay line
//   filterGain    loop filter multiplier
//   exciteEn      delay line writes noise instead of feedback
//   voiceActive   high in EXCITE, SUSTAIN and RELEASE
//   busy          high in every state except IDLE
//   noteReject    one-cycle pulse when a note request is refused
//
// All outputs are registered.

module ks_voice_sequencer #(
  parameter int                DELAY_W       = 10,
  parameter int                GAIN_W        = 11,
  parameter int                MIN_DELAY     = 16,
  parameter int                SUSTAIN_W     = 20,
  parameter int                SUSTAIN_MAX   = 96000,
  parameter int                RELEASE_TICKS = 4800,
  parameter logic [GAIN_W-1:0] RELEASE_GAIN  = 11'h3C0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sampleTick,
  input  logic               noteOn,
  input  logic               noteOff,
  input  logic [DELAY_W-1:0] noteDelay,
  input  logic [GAIN_W-1:0]  lutMul,
  output logic [DELAY_W-1:0] lutDelay,
  output logic [DELAY_W-1:0] delayLen,
  output logic [GAIN_W-1:0]  filterGain,
  output logic               exciteEn,
  output logic               voiceActive,
  output logic               busy,
  output logic               noteReject
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    EXCITE  = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [DELAY_W-1:0]   MIN_DELAY_V  = DELAY_W'(MIN_DELAY);
  localparam logic [SUSTAIN_W-1:0] SUSTAIN_LAST = SUSTAIN_W'(SUSTAIN_MAX - 1);
  localparam logic [SUSTAIN_W-1:0] RELEASE_LAST = SUSTAIN_W'(RELEASE_TICKS - 1);

  state_t               state;
  logic [DELAY_W-1:0]   delay_reg;
  logic [SUSTAIN_W-1:0] tick_cnt;
  logic                 pending_off;

  logic                 req_valid;
  logic                 start;
  logic                 reject;
  logic                 off_eff;
  logic [SUSTAIN_W-1:0] excite_last;

  assign req_valid = (noteDelay >= MIN_DELAY_V);

  // A new note may start from IDLE or retrigger from SUSTAIN/RELEASE; while
  // the LUT answer or the noise burst is in flight every request is refused.
  assign start  = noteOn && req_valid &&
                  (state == IDLE || state == SUSTAIN || state == RELEASE);
  assign reject = noteOn && (!req_valid || state == LOOKUP || state == EXCITE);

  // noteOn takes precedence: a noteOff arriving with it is dropped.
  assign off_eff = noteOff && !noteOn;

  // Excite leaves on the tick whose count equals delay-1, so the noise burst
  // lasts exactly delay samples and the counter never wraps.
  assign excite_last = SUSTAIN_W'(delay_reg) - SUSTAIN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      delay_reg   <= '0;
      tick_cnt    <= '0;
      pending_off <= 1'b0;
      lutDelay    <= '0;
      delayLen    <= '0;
      filterGain  <= '0;
      exciteEn    <= 1'b0;
      voiceActive <= 1'b0;
      busy        <= 1'b0;
      noteReject  <= 1'b0;
    end else begin
      noteReject <= reject;
      if (start) begin
        // filterGain keeps its value until LOOKUP captures the new LUT gain.
        state       <= LOOKUP;
        delay_reg   <= noteDelay;
        lutDelay    <= noteDelay;
        delayLen    <= noteDelay;
        tick_cnt    <= '0;
        pending_off <= 1'b0;
        exciteEn    <= 1'b0;
        voiceActive <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
          end

          LOOKUP: begin
            filterGain  <= lutMul;
            tick_cnt    <= '0;
            exciteEn    <= 1'b1;
            voiceActive <= 1'b1;
            state       <= EXCITE;
            if (off_eff) pending_off <= 1'b1;
          end

          EXCITE: begin
            if (off_eff) pending_off <= 1'b1;
            if (sampleTick) begin
              if (tick_cnt == excite_last) begin
                tick_cnt <= '0;
                exciteEn <= 1'b0;
                if (pending_off || off_eff) begin
                  state       <= RELEASE;
                  filterGain  <= RELEASE_GAIN;
                  pending_off <= 1'b0;
                end else begin
                  state <= SUSTAIN;
                end
              end else begin
                tick_cnt <= tick_cnt + SUSTAIN_W'(1);
              end
            end
          end

          SUSTAIN: begin
            if (off_eff || (sampleTick && tick_cnt == SUSTAIN_LAST)) begin
              state       <= RELEASE;
              filterGain  <= RELEASE_GAIN;
              tick_cnt    <= '0;
              pending_off <= 1'b0;
            end else if (sampleTick) begin
              tick_cnt <= tick_cnt + SUSTAIN_W'(1);
            end
          end

          RELEASE: begin
            // delayLen and lutDelay keep the last note's length after release.
            if (sampleTick) begin
              if (tick_cnt == RELEASE_LAST) begin
                state       <= IDLE;
                tick_cnt    <= '0;
                filterGain  <= '0;
                exciteEn    <= 1'b0;
                voiceActive <= 1'b0;
                busy        <= 1'b0;
              end else begin
                tick_cnt <= tick_cnt + SUSTAIN_W'(1);
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ks_voice_sequencer.sv
// Testbench for ks_voice_sequencer: directed note scenarios followed by random
// traffic. A note-level reference model (countdown of remaining samples per
// phase) pushes the expected registered outputs for each clock edge into a
// queue; an independent monitor pops one entry per edge and compares.

module tb_ks_voice_sequencer;

  localparam int          DELAY_W       = 10;
  localparam int          GAIN_W        = 11;
  localparam int          MIN_DELAY     = 16;
  localparam int          SUSTAIN_W     = 20;
  localparam int          SUSTAIN_MAX   = 50;
  localparam int          RELEASE_TICKS = 20;
  localparam logic [10:0] RELEASE_GAIN  = 11'h3C0;

  logic               clk = 1'b0;
  logic               reset;
  logic               sampleTick;
  logic               noteOn;
  logic               noteOff;
  logic [DELAY_W-1:0] noteDelay;
  logic [GAIN_W-1:0]  lutMul;
  logic [DELAY_W-1:0] lutDelay;
  logic [DELAY_W-1:0] delayLen;
  logic [GAIN_W-1:0]  filterGain;
  logic               exciteEn;
  logic               voiceActive;
  logic               busy;
  logic               noteReject;

  always #5 clk = ~clk;

  ks_voice_sequencer #(
    .DELAY_W      (DELAY_W),
    .GAIN_W       (GAIN_W),
    .MIN_DELAY    (MIN_DELAY),
    .SUSTAIN_W    (SUSTAIN_W),
    .SUSTAIN_MAX  (SUSTAIN_MAX),
    .RELEASE_TICKS(RELEASE_TICKS),
    .RELEASE_GAIN (RELEASE_GAIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sampleTick (sampleTick),
    .noteOn     (noteOn),
    .noteOff    (noteOff),
    .noteDelay  (noteDelay),
    .lutMul     (lutMul),
    .lutDelay   (lutDelay),
    .delayLen   (delayLen),
    .filterGain (filterGain),
    .exciteEn   (exciteEn),
    .voiceActive(voiceActive),
    .busy       (busy),
    .noteReject (noteReject)
  );

  // Delay-to-gain LUT stand-in: 100 -> 0x3FC, 300 -> 0x3F6.
  function automatic logic [10:0] lut_gain(input logic [9:0] d);
    int g;
    g = 1023 - (3 * int'(d)) / 100;
    return 11'(g);
  endfunction

  assign lutMul = lut_gain(lutDelay);

  typedef struct packed {
    logic [9:0]  lut;
    logic [9:0]  len;
    logic [10:0] gain;
    logic        exc;
    logic        act;
    logic        bsy;
    logic        rej;
  } snap_t;

  typedef enum int {P_IDLE, P_LOOKUP, P_EXCITE, P_SUSTAIN, P_RELEASE} phase_t;

  snap_t  exp_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: phase plus samples remaining in it.
  phase_t ph   = P_IDLE;
  int     left = 0;
  int     dly  = 0;
  bit     pend = 1'b0;
  snap_t  m    = '0;

  task automatic start_note(input logic [9:0] nd);
    m.lut = nd;
    m.len = nd;
    dly   = int'(nd);
    ph    = P_LOOKUP;
    m.exc = 1'b0;
    m.act = 1'b0;
    m.bsy = 1'b1;
    pend  = 1'b0;
  endtask

  task automatic enter_release();
    ph     = P_RELEASE;
    left   = RELEASE_TICKS;
    m.gain = RELEASE_GAIN;
    pend   = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit on, input bit off,
                            input bit tick, input logic [9:0] nd);
    bit valid;
    valid = (int'(nd) >= MIN_DELAY);
    m.rej = 1'b0;
    if (rst) begin
      m    = '0;
      ph   = P_IDLE;
      left = 0;
      dly  = 0;
      pend = 1'b0;
    end else begin
      case (ph)
        P_IDLE: begin
          if (on) begin
            if (valid) start_note(nd);
            else m.rej = 1'b1;
          end
        end
        P_LOOKUP: begin
          if (on) m.rej = 1'b1;
          else if (off) pend = 1'b1;
          m.gain = lut_gain(m.lut);
          left   = dly;
          ph     = P_EXCITE;
          m.exc  = 1'b1;
          m.act  = 1'b1;
        end
        P_EXCITE: begin
          if (on) m.rej = 1'b1;
          else if (off) pend = 1'b1;
          if (tick) begin
            left = left - 1;
            if (left == 0) begin
              m.exc = 1'b0;
              if (pend) enter_release();
              else begin
                ph   = P_SUSTAIN;
                left = SUSTAIN_MAX;
              end
            end
          end
        end
        P_SUSTAIN: begin
          if (on) begin
            if (valid) start_note(nd);
            else m.rej = 1'b1;
          end else if (off) begin
            enter_release();
          end else if (tick) begin
            left = left - 1;
            if (left == 0) enter_release();
          end
        end
        P_RELEASE: begin
          if (on) begin
            if (valid) start_note(nd);
            else m.rej = 1'b1;
          end else if (tick) begin
            left = left - 1;
            if (left == 0) begin
              ph     = P_IDLE;
              m.gain = '0;
              m.exc  = 1'b0;
              m.act  = 1'b0;
              m.bsy  = 1'b0;
            end
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  endtask

  // One clock: drive inputs on the falling edge, predict the next edge.
  task automatic step(input bit rst, input bit on, input bit off,
                      input bit tick, input logic [9:0] nd);
    @(negedge clk);
    reset      = rst;
    noteOn     = on;
    noteOff    = off;
    sampleTick = tick;
    noteDelay  = nd;
    model_step(rst, on, off, tick, nd);
    exp_q.push_back(m);
  endtask

  task automatic idle(input int n, input int period);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, (i % period) == 0, 10'd0);
  endtask

  // Monitor: compare one expected snapshot per clock edge.
  snap_t e_s;
  snap_t a_s;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e_s = exp_q.pop_front();
        a_s = {lutDelay, delayLen, filterGain, exciteEn, voiceActive, busy, noteReject};
        checks++;
        if (a_s !== e_s) begin
          errors++;
          if (errors <= 20)
            $display("FAIL outputs @%0t: got lut=%0d len=%0d gain=%h exc=%b act=%b busy=%b rej=%b, want lut=%0d len=%0d gain=%h exc=%b act=%b busy=%b rej=%b",
                     $time, a_s.lut, a_s.len, a_s.gain, a_s.exc, a_s.act, a_s.bsy, a_s.rej,
                     e_s.lut, e_s.len, e_s.gain, e_s.exc, e_s.act, e_s.bsy, e_s.rej);
        end
      end
    end
  end

  initial begin
    bit          r_on, r_off, r_tick, r_rst;
    logic [9:0]  r_nd;
    reset      = 1'b1;
    noteOn     = 1'b0;
    noteOff    = 1'b0;
    sampleTick = 1'b0;
    noteDelay  = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 10'd0);

    // Basic note: delay 100, excite, sustain timeout, release to IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd100);
    idle(200, 1);

    // Too-short request is refused.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd8);
    idle(5, 1);

    // noteOff during excite: the burst completes, then release.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd60);
    idle(22, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
    idle(120, 2);

    // noteOff while in LOOKUP is remembered.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    idle(60, 1);

    // Retrigger from sustain with 300, then a refused request mid-excite.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd100);
    idle(110, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd300);
    idle(10, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 10'd50);
    idle(400, 1);

    // noteOff in sustain, then retrigger from release.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd30);
    idle(40, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    idle(5, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd700);
    idle(20, 1);

    // Reset mid-excite, then a new note.
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd200);
    idle(30, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd40);
    idle(150, 1);

    // Threshold edges: 15 refused, 16 accepted.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd15);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd16);
    idle(100, 1);

    // Random traffic.
    for (int i = 0; i < 6000; i++) begin
      r_on   = ($urandom_range(0, 59) == 0);
      r_off  = !r_on && ($urandom_range(0, 79) == 0);
      r_tick = ($urandom_range(0, 2) == 0);
      r_rst  = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 9) == 0) r_nd = 10'($urandom_range(0, 15));
      else                           r_nd = 10'($urandom_range(16, 400));
      step(r_rst, r_on, r_off, r_tick, r_nd);
    end
    idle(2, 1);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
